// File: rtl/spec_fence_pkg.sv
// ----------------------------------------------------------------------------
// spec_fence_pkg
//
// Shared definitions for the speculative load gate. Holds the default
// parameter values, the helper that sizes the outstanding-branch counter
// from its maximum value, and the held-load entry layout.
//
// Contents:
//   DEFAULT_DEPTH / DEFAULT_MAX_BR / DEFAULT_TAG_W : default parameters
//   fenceCountWidth(maxBr) : bits needed to count 0..maxBr
//   DEFAULT_CW             : counter width for the default MAX_BR
//   held_load_t            : {valid, older, tag} entry at default widths
// ----------------------------------------------------------------------------
package spec_fence_pkg;

    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_MAX_BR = 15;
    localparam int DEFAULT_TAG_W  = 6;

    // Width of a counter that must hold every value from 0 up to maxBr.
    function automatic int fenceCountWidth(input int maxBr);
        return $clog2(maxBr + 1);
    endfunction

    localparam int DEFAULT_CW = fenceCountWidth(DEFAULT_MAX_BR);

    // One held load: older counts the branches that must still retire
    // before this load may issue.
    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_CW-1:0]    older;
        logic [DEFAULT_TAG_W-1:0] tag;
    } held_load_t;

endpackage

// File: rtl/fence_branch_counter.sv
// ----------------------------------------------------------------------------
// fence_branch_counter
//
// Tracks the number of dispatched-but-unretired branches. It gives the
// load queue the next-cycle count, which becomes the age of a load enqueued
// this cycle. It also gives a strobe that tells every held load that one
// older branch has retired.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush_i           : clears the count; same-cycle dispatch/retire ignored
//   br_dispatch_i     : one branch dispatched this cycle
//   br_retire_i       : oldest branch retired this cycle
//   pending_o         : registered outstanding branch count
//   pending_next_o    : count after this cycle's dispatch/retire (no flush)
//   retire_accept_o   : retire that actually decrements (not ignored/flushed)
//   br_stall_o        : count is at MAX_BR, front end must hold branches
// ----------------------------------------------------------------------------
module fence_branch_counter
    import spec_fence_pkg::*;
#(
    parameter int MAX_BR = DEFAULT_MAX_BR
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         br_dispatch_i,
    input  logic                         br_retire_i,
    output logic [$clog2(MAX_BR+1)-1:0]  pending_o,
    output logic [$clog2(MAX_BR+1)-1:0]  pending_next_o,
    output logic                         retire_accept_o,
    output logic                         br_stall_o
);

    localparam int CW = fenceCountWidth(MAX_BR);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BR);

    logic [CW-1:0] pending_q;
    logic [CW-1:0] pending_d;
    logic          brStall_q;
    logic          retireAccept;

    // A retire only counts when there is something to retire: either a branch
    // already outstanding or one arriving in the same cycle. Dispatch at the
    // maximum without a retire is illegal, so the count simply holds there.
    always_comb begin
        retireAccept = br_retire_i && ((pending_q != '0) || br_dispatch_i);
        pending_d    = pending_q;
        if (br_dispatch_i && !retireAccept) begin
            if (pending_q != MAX_CNT) begin
                pending_d = pending_q + 1'b1;
            end
        end else if (!br_dispatch_i && retireAccept) begin
            pending_d = pending_q - 1'b1;
        end
    end

    // The stall flag is computed from the next count, so it lines up exactly
    // with the registered count it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            brStall_q <= 1'b0;
        end else if (flush_i) begin
            pending_q <= '0;
            brStall_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            brStall_q <= (pending_d == MAX_CNT);
        end
    end

    assign pending_o       = pending_q;
    assign pending_next_o  = pending_d;
    assign retire_accept_o = retireAccept && !flush_i;
    assign br_stall_o      = brStall_q;

    // The front end must respect br_stall_o; a further dispatch at the
    // maximum would lose a branch.
    a_no_dispatch_at_max : assert property (@(posedge clk) disable iff (!rst_n)
        !(br_dispatch_i && !br_retire_i && !flush_i && (pending_q == MAX_CNT)));

endmodule

// File: rtl/spec_load_gate_ctrl.sv
// ----------------------------------------------------------------------------
// spec_load_gate_ctrl
//
// Holds loads from dispatch in an in-order queue. Each load is stamped with the
// number of branches older than it. The head issues to the LSU once that
// number reaches zero, or at once when gating is disabled. A flush drops all
// held loads and clears the branch count.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable_i        : 1 = gate loads behind older branches, 0 = pass in order
//   flush_i         : drop held loads and outstanding branches
//   br_dispatch_i   : branch dispatched this cycle
//   br_retire_i     : oldest branch retired this cycle
//   br_stall_o      : branch counter full
//   pending_br_o    : outstanding branch count
//   ld_valid_i      : load request from dispatch
//   ld_tag_i        : load tag (LSQ index)
//   ld_ready_o      : queue can accept a load (registered)
//   ld_valid_o      : head load may issue
//   ld_tag_o        : head load tag (0 when queue empty)
//   ld_ready_i      : LSU accepts the head load
//   stall_cycles_o  : saturating count of cycles the head was held back
// ----------------------------------------------------------------------------
module spec_load_gate_ctrl
    import spec_fence_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int MAX_BR = DEFAULT_MAX_BR,
    parameter int TAG_W  = DEFAULT_TAG_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable_i,
    input  logic                         flush_i,
    input  logic                         br_dispatch_i,
    input  logic                         br_retire_i,
    output logic                         br_stall_o,
    output logic [$clog2(MAX_BR+1)-1:0]  pending_br_o,
    input  logic                         ld_valid_i,
    input  logic [TAG_W-1:0]             ld_tag_i,
    output logic                         ld_ready_o,
    output logic                         ld_valid_o,
    output logic [TAG_W-1:0]             ld_tag_o,
    input  logic                         ld_ready_i,
    output logic [31:0]                  stall_cycles_o
);

    localparam int CW = fenceCountWidth(MAX_BR);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = PW + 1;
    localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

    // Same layout as held_load_t, sized by this instance's parameters.
    typedef struct packed {
        logic             valid;
        logic [CW-1:0]    older;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t        queue_q [DEPTH];
    entry_t        queue_d [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] head_d;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] tail_d;
    logic [NW-1:0] count_q;
    logic [NW-1:0] count_d;
    logic          ready_q;
    logic [31:0]   stallCycles_q;

    logic [CW-1:0] pendingNext;
    logic          retireAccept;
    entry_t        headEntry;
    logic          headValid;
    logic          push;
    logic          pop;

    fence_branch_counter #(
        .MAX_BR (MAX_BR)
    ) u_branch_counter (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .br_dispatch_i   (br_dispatch_i),
        .br_retire_i     (br_retire_i),
        .pending_o       (pending_br_o),
        .pending_next_o  (pendingNext),
        .retire_accept_o (retireAccept),
        .br_stall_o      (br_stall_o)
    );

    // Issue decision comes straight from the registered head entry, so a load
    // can issue no earlier than the cycle after it was enqueued. Once older
    // reaches zero it never rises again, which keeps valid and tag stable
    // until the LSU takes the load.
    always_comb begin
        headEntry  = queue_q[head_q];
        headValid  = headEntry.valid;
        ld_valid_o = headValid && ((headEntry.older == '0) || !enable_i);
        ld_tag_o   = headValid ? headEntry.tag : '0;
        push       = ld_valid_i && ready_q && !flush_i;
        pop        = ld_valid_o && ld_ready_i && !flush_i;
    end

    // Next queue state. The retire decrement is applied to existing entries
    // first. A newly written entry then overwrites its slot with the
    // post-retire count, so it is not decremented twice. Push and pop never
    // touch the same slot because push requires the queue not to be full.
    always_comb begin
        queue_d = queue_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (retireAccept && queue_q[i].valid && (queue_q[i].older != '0)) begin
                queue_d[i].older = queue_q[i].older - 1'b1;
            end
        end

        if (pop) begin
            queue_d[head_q].valid = 1'b0;
            head_d                = head_q + 1'b1;
        end

        if (push) begin
            queue_d[tail_q].valid = 1'b1;
            queue_d[tail_q].older = pendingNext;
            queue_d[tail_q].tag   = ld_tag_i;
            tail_d                = tail_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Queue storage and pointers. Ready is registered from the next count so
    // the producer sees a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            queue_q <= queue_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= (count_d != FULL_CNT);
        end
    end

    // Counts cycles where a load sits at the head but is held back by an
    // older branch. Flush leaves it alone; it is a lifetime statistic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCycles_q <= '0;
        end else if (headValid && !ld_valid_o && (stallCycles_q != '1)) begin
            stallCycles_q <= stallCycles_q + 32'd1;
        end
    end

    assign ld_ready_o     = ready_q;
    assign stall_cycles_o = stallCycles_q;

    // Gating mode must not change under held loads, or a gated head could
    // appear to issue and then retract.
    a_enable_only_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
        !$stable(enable_i) |-> (count_q == '0));

    // An offered load stays offered with the same tag until taken or flushed.
    a_issue_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (ld_valid_o && !ld_ready_i && !flush_i) |=> (ld_valid_o && $stable(ld_tag_o)));

endmodule
